// File: rtl/ace_aw_snoop_issuer.sv
// ace_aw_snoop_issuer
//   Sits downstream of the AW transaction decoder in the ACE write path. It takes
//   one AW beat at a time, together with the decoder verdict. If snooping is
//   needed, it broadcasts one AC request to every port except the originator and
//   collects all CR responses. It then forwards the AW with the OR-ed DataTransfer
//   and Error results. Illegal AWs are dropped, and a one-cycle error pulse
//   reports the drop.
// Ports
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   aw_valid_i/aw_ready_o/aw_i    upstream AW channel, plus src_idx_i,
//                                 acsnoop_i, snooping_i and illegal_trs_i
//   ac_valid_o/ac_ready_i         per-port AC handshake; ac_addr_o, ac_snoop_o
//                                 and ac_prot_o are shared by all ports
//   cr_valid_i/cr_ready_o         per-port CR handshake with a 5-bit cr_resp_i
//   aw_valid_o/aw_ready_i/aw_o    downstream AW channel, with snoop_data_o and
//                                 snoop_err_o
//   illegal_o                     pulse: an illegal AW was accepted and dropped

package ace_aw_snoop_issuer_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [2:0]  prot;
    logic [2:0]  snoop;
    logic [1:0]  domain;
    logic [1:0]  bar;
  } aw_chan_t;
endpackage

module ace_aw_snoop_issuer #(
  parameter int unsigned NumPorts = 2,
  // AddrW must match the width of aw_chan_t.addr
  parameter int unsigned AddrW    = 32,
  parameter type         aw_chan_t = ace_aw_snoop_issuer_pkg::aw_chan_t,
  parameter int unsigned IdxW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     aw_valid_i,
  output logic                     aw_ready_o,
  input  aw_chan_t                 aw_i,
  input  logic [IdxW-1:0]          src_idx_i,
  input  logic [3:0]               acsnoop_i,
  input  logic                     snooping_i,
  input  logic                     illegal_trs_i,
  output logic [NumPorts-1:0]      ac_valid_o,
  input  logic [NumPorts-1:0]      ac_ready_i,
  output logic [AddrW-1:0]         ac_addr_o,
  output logic [3:0]               ac_snoop_o,
  output logic [2:0]               ac_prot_o,
  input  logic [NumPorts-1:0]      cr_valid_i,
  output logic [NumPorts-1:0]      cr_ready_o,
  input  logic [NumPorts-1:0][4:0] cr_resp_i,
  output logic                     aw_valid_o,
  input  logic                     aw_ready_i,
  output aw_chan_t                 aw_o,
  output logic                     snoop_data_o,
  output logic                     snoop_err_o,
  output logic                     illegal_o
);

  typedef enum logic [1:0] {IDLE, SNOOP, FWD} state_e;

  state_e              state_q, state_d;
  aw_chan_t            aw_q, aw_d;
  logic [3:0]          acsnoop_q, acsnoop_d;
  logic [NumPorts-1:0] ac_pend_q, ac_pend_d;
  logic [NumPorts-1:0] cr_pend_q, cr_pend_d;
  logic                data_q, data_d;
  logic                err_q, err_d;
  logic                illegal_q, illegal_d;

  logic [NumPorts-1:0] snoop_mask;
  logic [NumPorts-1:0] ac_hs;
  logic [NumPorts-1:0] cr_hs;
  logic [NumPorts-1:0] resp_data;
  logic [NumPorts-1:0] resp_err;
  logic                resp_unused;

  // After capture, the originator exists only as the missing bit in the
  // pending masks. This is why src_idx_i does not need its own register.
  assign snoop_mask = ~(NumPorts'(1) << src_idx_i);

  // A CR is taken only once the AC on the same port has completed.
  assign cr_ready_o = cr_pend_q & ~ac_pend_q;
  assign ac_hs      = ac_pend_q & ac_ready_i;
  assign cr_hs      = cr_valid_i & cr_ready_o;

  always_comb begin
    resp_data = '0;
    resp_err  = '0;
    for (int p = 0; p < NumPorts; p++) begin
      resp_data[p] = cr_resp_i[p][0];
      resp_err[p]  = cr_resp_i[p][1];
    end
  end

  // PassDirty/IsShared/WasUnique are not used for the write-path aggregate.
  assign resp_unused = ^cr_resp_i;

  assign aw_ready_o   = (state_q == IDLE);
  assign aw_valid_o   = (state_q == FWD);
  assign ac_valid_o   = ac_pend_q;
  assign aw_o         = aw_q;
  assign ac_addr_o    = aw_q.addr;
  assign ac_prot_o    = aw_q.prot;
  assign ac_snoop_o   = acsnoop_q;
  assign snoop_data_o = data_q;
  assign snoop_err_o  = err_q;
  assign illegal_o    = illegal_q;

  always_comb begin
    state_d   = state_q;
    aw_d      = aw_q;
    acsnoop_d = acsnoop_q;
    ac_pend_d = ac_pend_q;
    cr_pend_d = cr_pend_q;
    data_d    = data_q;
    err_d     = err_q;
    illegal_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (aw_valid_i) begin
          aw_d      = aw_i;
          acsnoop_d = acsnoop_i;
          data_d    = 1'b0;
          err_d     = 1'b0;
          // An illegal verdict overrides a snoop request.
          if (illegal_trs_i) begin
            illegal_d = 1'b1;
          end else if (snooping_i && (snoop_mask != '0)) begin
            ac_pend_d = snoop_mask;
            cr_pend_d = snoop_mask;
            state_d   = SNOOP;
          end else begin
            state_d   = FWD;
          end
        end
      end
      SNOOP: begin
        ac_pend_d = ac_pend_q & ~ac_hs;
        cr_pend_d = cr_pend_q & ~cr_hs;
        data_d    = data_q | (|(cr_hs & resp_data));
        err_d     = err_q  | (|(cr_hs & resp_err));
        if ((ac_pend_d == '0) && (cr_pend_d == '0)) begin
          state_d = FWD;
        end
      end
      FWD: begin
        if (aw_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      aw_q      <= '0;
      acsnoop_q <= '0;
      ac_pend_q <= '0;
      cr_pend_q <= '0;
      data_q    <= 1'b0;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_q      <= aw_d;
      acsnoop_q <= acsnoop_d;
      ac_pend_q <= ac_pend_d;
      cr_pend_q <= cr_pend_d;
      data_q    <= data_d;
      err_q     <= err_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
